// File: rtl/draw_pkg.sv
// Shared geometry/colour widths and the rectangle descriptor for the overlay.
// Sums use SUM_W (one bit wider than coordinates) so x+w never wraps.
package draw_pkg;
   localparam int COORD_W = 11;
   localparam int RGB_W   = 12;
   localparam int SUM_W   = 12;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] w;
      logic [COORD_W-1:0] h;
      logic [RGB_W-1:0]   color;
      logic               en;
      logic               blink;
   } rect_cfg_t;
endpackage

// File: rtl/vga_if.sv
// VGA timing plus pixel colour bundle; "in" is the consumer view, "out" the producer view.
// Pure wiring: no latency, no backpressure.
interface vga_if;
   logic [draw_pkg::COORD_W-1:0] hcount;
   logic [draw_pkg::COORD_W-1:0] vcount;
   logic                         hsync;
   logic                         vsync;
   logic                         hblnk;
   logic                         vblnk;
   logic [draw_pkg::RGB_W-1:0]   rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_rect_hit.sv
// Combinational test of one pixel against one enabled rectangle.
// Latency 0; no backpressure. w or h of zero can never hit.
module draw_rect_hit
   import draw_pkg::*;
(
   input  logic [COORD_W-1:0] hcount,
   input  logic [COORD_W-1:0] vcount,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] w,
   input  logic [COORD_W-1:0] h,
   input  logic               en,
   output logic               hit
);
   logic [SUM_W-1:0] x_end;
   logic [SUM_W-1:0] y_end;
   logic             in_x;
   logic             in_y;

   always_comb begin
      x_end = SUM_W'(x) + SUM_W'(w);
      y_end = SUM_W'(y) + SUM_W'(h);
      in_x  = (hcount >= x) && (SUM_W'(hcount) < x_end);
      in_y  = (vcount >= y) && (SUM_W'(vcount) < y_end);
      hit   = en && in_x && in_y;
   end
endmodule

// File: rtl/draw_rect_multi.sv
// Overlays N_RECT shadow-buffered rectangles on a VGA stream; config commits on each vblnk rise.
// Latency 2 clk for every vga_out field; cfg_ready drops only in the commit cycle.
module draw_rect_multi
   import draw_pkg::*;
#(
   parameter int  N_RECT           = 4,
   parameter int  BLINK_FRAMES     = 30,
   parameter int  PRIORITY_LOW_IDX = 1,
   localparam int IDX_W            = (N_RECT > 1) ? $clog2(N_RECT) : 1
)(
   input  logic             clk,
   input  logic             rst,
   vga_if.in                vga_in,
   vga_if.out               vga_out,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [IDX_W-1:0] cfg_idx,
   input  rect_cfg_t        cfg_rect,
   output logic             frame_tick
);
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   rect_cfg_t          shadow [N_RECT];
   rect_cfg_t          active [N_RECT];
   logic               run_q;
   logic               vblnk_d;
   logic               commit;
   logic               wr_en;
   logic [FC_W-1:0]    frame_cnt;
   logic               blink_phase;
   logic [N_RECT-1:0]  hit_raw;
   logic [N_RECT-1:0]  hit_vis;
   logic [N_RECT-1:0]  hit_q;
   logic [COORD_W-1:0] s1_hcount;
   logic [COORD_W-1:0] s1_vcount;
   logic               s1_hsync;
   logic               s1_vsync;
   logic               s1_hblnk;
   logic               s1_vblnk;
   logic [RGB_W-1:0]   s1_rgb;
   logic [RGB_W-1:0]   sel_rgb;

   // run_q keeps the first post-reset cycle from seeing a false vblnk edge
   assign commit     = run_q & vga_in.vblnk & ~vblnk_d;
   assign cfg_ready  = run_q & ~commit;
   assign frame_tick = commit;
   assign wr_en      = cfg_valid & cfg_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q       <= 1'b0;
         vblnk_d     <= 1'b0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         run_q   <= 1'b1;
         vblnk_d <= vga_in.vblnk;
         if (commit) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   // Out-of-range indices match no entry, so those writes are accepted and dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_RECT; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_RECT; i++) begin
            if (wr_en && (cfg_idx == IDX_W'(i)))
               shadow[i] <= cfg_rect;
            if (commit)
               active[i] <= shadow[i];
         end
      end
   end

   for (genvar g = 0; g < N_RECT; g++) begin : g_hit
      draw_rect_hit u_hit (
         .hcount (vga_in.hcount),
         .vcount (vga_in.vcount),
         .x      (active[g].x),
         .y      (active[g].y),
         .w      (active[g].w),
         .h      (active[g].h),
         .en     (active[g].en),
         .hit    (hit_raw[g])
      );
   end

   always_comb begin
      hit_vis = '0;
      if (!(vga_in.hblnk || vga_in.vblnk)) begin
         for (int i = 0; i < N_RECT; i++)
            hit_vis[i] = hit_raw[i] & ~(active[i].blink & blink_phase);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_q     <= '0;
         s1_hcount <= '0;
         s1_vcount <= '0;
         s1_hsync  <= 1'b0;
         s1_vsync  <= 1'b0;
         s1_hblnk  <= 1'b0;
         s1_vblnk  <= 1'b0;
         s1_rgb    <= '0;
      end else begin
         hit_q     <= hit_vis;
         s1_hcount <= vga_in.hcount;
         s1_vcount <= vga_in.vcount;
         s1_hsync  <= vga_in.hsync;
         s1_vsync  <= vga_in.vsync;
         s1_hblnk  <= vga_in.hblnk;
         s1_vblnk  <= vga_in.vblnk;
         s1_rgb    <= vga_in.rgb;
      end
   end

   // Later assignment wins, so the loop direction sets the priority
   always_comb begin
      sel_rgb = s1_rgb;
      if (PRIORITY_LOW_IDX != 0) begin
         for (int i = N_RECT - 1; i >= 0; i--)
            if (hit_q[i]) sel_rgb = active[i].color;
      end else begin
         for (int i = 0; i < N_RECT; i++)
            if (hit_q[i]) sel_rgb = active[i].color;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vga_out.hcount <= '0;
         vga_out.vcount <= '0;
         vga_out.hsync  <= 1'b0;
         vga_out.vsync  <= 1'b0;
         vga_out.hblnk  <= 1'b0;
         vga_out.vblnk  <= 1'b0;
         vga_out.rgb    <= '0;
      end else begin
         vga_out.hcount <= s1_hcount;
         vga_out.vcount <= s1_vcount;
         vga_out.hsync  <= s1_hsync;
         vga_out.vsync  <= s1_vsync;
         vga_out.hblnk  <= s1_hblnk;
         vga_out.vblnk  <= s1_vblnk;
         vga_out.rgb    <= sel_rgb;
      end
   end
endmodule

// File: doc/draw_rect_multi.md
DRAW_RECT_MULTI -- requirements
Module: draw_rect_multi

Interface
REQ-001 Parameter N_RECT, default 4: number of rectangles, 1..16.
REQ-002 Parameter BLINK_FRAMES, default 30: frames per blink half-period, at least 1.
REQ-003 Parameter PRIORITY_LOW_IDX, default 1: if 1, the lowest-index hit wins; if 0, the highest-index hit wins.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: pixel clock.
REQ-006 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-007 Port vga_in, vga_if.in: upstream timing (hcount/vcount 11 b; hsync, vsync, hblnk, vblnk) and rgb 12 b.
REQ-008 Port vga_out, vga_if.out: downstream timing and rgb.
REQ-009 Port cfg_valid, input, 1 bit: a configuration write is offered.
REQ-010 Port cfg_ready, output, 1 bit: the block accepts the write this cycle.
REQ-011 Port cfg_idx, input, $clog2(N_RECT) bits (min 1): target rectangle index.
REQ-012 Port cfg_rect, input, rect_cfg_t: x 11 b, y 11 b, w 11 b, h 11 b, color 12 b, en 1 b, blink 1 b.
REQ-013 Port frame_tick, output, 1 bit: one-cycle pulse at each commit.

Function
REQ-014 A write SHALL be accepted when cfg_valid and cfg_ready are both 1; it updates shadow[cfg_idx] only.
REQ-015 A write with cfg_idx >= N_RECT SHALL be accepted and discarded.
REQ-016 The commit cycle SHALL be the cycle in which vga_in.vblnk rises (0->1, registered edge detect).
REQ-017 In the commit cycle, active[i] <= shadow[i] for all i, frame_tick = 1, and cfg_ready = 0.
REQ-018 In all other cycles out of reset, cfg_ready SHALL be 1.
REQ-019 A write accepted in the cycle before the commit cycle SHALL be included in that commit.
REQ-020 Rectangle i SHALL hit when its active en is 1, x <= hcount < x+w, and y <= vcount < y+h.
REQ-021 Sums SHALL be computed 12 b wide, with no wrap; w = 0 or h = 0 never hits.
REQ-022 A rectangle with blink = 1 SHALL be suppressed while blink_phase = 1.
REQ-023 The frame counter SHALL count commits 0..BLINK_FRAMES-1 and wrap to 0.
REQ-024 blink_phase SHALL toggle on each wrap of the frame counter.
REQ-025 Pipeline stage 1 SHALL register the N_RECT hit vector plus delayed timing and rgb.
REQ-026 Pipeline stage 2 SHALL priority-select the winning color, or pass rgb if there is no hit, and register it to vga_out.
REQ-027 Latency SHALL be exactly 2 clk cycles for all vga_out fields; timing stays aligned with rgb.
REQ-028 Pixels with hblnk or vblnk = 1 SHALL pass vga_in.rgb unchanged.

Reset
REQ-029 On rst = 0, all vga_out fields, frame_tick, cfg_ready, the frame counter, blink_phase and the edge-detect register SHALL go to 0 immediately.
REQ-030 On rst = 0, all shadow and active entries SHALL be cleared (en = 0).
REQ-031 Reset asserted mid-frame SHALL drop pending shadow writes; after release, nothing is drawn until writes are followed by a commit.
REQ-032 cfg_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-033 Package draw_pkg SHALL hold rect_cfg_t, coordinate width constant (11), rgb width constant (12) and sum width (12).
REQ-034 Sub-module draw_rect_hit SHALL perform one combinational rectangle/pixel comparison and SHALL be instantiated N_RECT times via generate.
REQ-035 Priority select, commit logic and the blink counter SHALL reside in draw_rect_multi.

Verification
REQ-036 Write idx 0 {x=100, y=50, w=8, h=8, color=F00, en=1}, then commit: pixels (100,50) and (107,57) output F00; (108,57) and (107,58) pass input rgb; latency 2.
REQ-037 Overlap: idx 0 = F00 and idx 1 = 0F0, both at (10,10, 4x4); with PRIORITY_LOW_IDX = 1 output F00, with 0 output 0F0.
REQ-038 Write issued mid-frame: the current frame is unchanged; the new rectangle appears from the frame after the next vblnk rise; frame_tick pulses 1 cycle there; cfg_ready = 0 that cycle.
REQ-039 Edge geometry: x = 2040, w = 20 draws to hcount 2047 with no wrap to 0; w = 0 draws nothing.
REQ-040 Blink with BLINK_FRAMES = 2, blink = 1: visible for 2 frames, hidden for 2, visible again.
REQ-041 Assert rst mid-line: outputs go to 0 asynchronously; after release, rgb passes through unmodified until a new write and commit.
